// File: rtl/apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// apb_master_ctrl
//
// Single-outstanding APB4 requester. Accepts one command on a valid/ready
// command channel, runs the APB setup/access sequence with a stable bus until
// the slave signals pready, then presents read data and error status on a
// valid/ready response channel. The next command is accepted only after the
// response handshake.
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   defined   : access-phase watchdog. If the slave has not raised pready
//               after TIMEOUT_CYCLES access cycles, the transfer is abandoned
//               and answered with rsp_err=1, rsp_rdata=0.
//   undefined : the access phase waits for pready indefinitely.
//
// Parameters
//   TIMEOUT_CYCLES  access cycles allowed before abort (2..65535)
//
// Ports
//   pclk, presetn          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot   command payload
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata, rsp_err     response payload (rdata is 0 for writes)
//   psel, penable, pwrite, paddr, pprot, pwdata, pwstrb   APB request
//   pready, prdata, pslverr                               APB completion
// -----------------------------------------------------------------------------
module apb_master_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  input  logic [2:0]  cmd_prot,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [15:0] paddr,
  output logic [2:0]  pprot,
  output logic [31:0] pwdata,
  output logic [3:0]  pwstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_master_ctrl: TIMEOUT_CYCLES must be within 2..65535");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  // Counts access cycles spent waiting; cleared while in SETUP so it reads
  // zero in the first access cycle.
  logic [15:0] wait_cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !pready) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // A pready arriving on the limit cycle still completes normally.
  assign timeout_hit = (state == ACCESS) && !pready && (wait_cnt == TIMEOUT_LIMIT);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs decode directly from the state register.
  assign cmd_ready = (state == IDLE);
  assign psel      = (state == SETUP) || (state == ACCESS);
  assign penable   = (state == ACCESS);
  assign rsp_valid = (state == RESP);

  // Payload and response registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pwrite    <= 1'b0;
      paddr     <= '0;
      pprot     <= '0;
      pwdata    <= '0;
      pwstrb    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pprot  <= cmd_prot;
        pwdata <= cmd_wdata;
        // Reads must present an all-zero strobe on the bus.
        pwstrb <= cmd_write ? cmd_wstrb : 4'b0000;
      end
      if (state == ACCESS) begin
        if (pready) begin
          rsp_rdata <= pwrite ? 32'h0 : prdata;
          rsp_err   <= pslverr;
        end else if (timeout_hit) begin
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_master_ctrl
//
// Directed bench for apb_master_ctrl with a small register-bank slave model
// (programmable wait states and error response). Expected responses are queued
// when a command is issued; a forked monitor pops and compares on every
// response handshake. Bus timing and stability are checked inline.
// -----------------------------------------------------------------------------
module tb_apb_master_ctrl;

  logic        pclk;
  logic        presetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pwstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  apb_master_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .cmd_prot  (cmd_prot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pprot     (pprot),
    .pwdata    (pwdata),
    .pwstrb    (pwstrb),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // ---------------- slave model: 16-word register bank ----------------
  logic [31:0] mem [0:15];
  int          acc_cnt;
  int          wait_states;
  logic        err_mode;

  always_comb begin
    pready  = psel && penable && (acc_cnt == wait_states);
    prdata  = mem[paddr[5:2]];
    pslverr = pready && err_mode;
  end

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      acc_cnt <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else                            acc_cnt <= 0;
      if (psel && penable && pready && pwrite && !err_mode) begin
        for (int b = 0; b < 4; b++)
          if (pwstrb[b]) mem[paddr[5:2]][8*b +: 8] <= pwdata[8*b +: 8];
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   rsp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge pclk);
      if (presetn && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rdata=0x%08h err=%b expected no response",
                   rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          rsp_cnt++;
          $display("rsp %0d: rdata=0x%08h err=%b (expect 0x%08h/%b)",
                   rsp_cnt, rsp_rdata, rsp_err, e.rdata, e.err);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
    check({tag, " psel"},      {31'h0, psel},      32'h0);
    check({tag, " penable"},   {31'h0, penable},   32'h0);
    check({tag, " pwrite"},    {31'h0, pwrite},    32'h0);
    check({tag, " rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, " rsp_err"},   {31'h0, rsp_err},   32'h0);
    check({tag, " paddr"},     {16'h0, paddr},     32'h0);
    check({tag, " pprot"},     {29'h0, pprot},     32'h0);
    check({tag, " pwdata"},    pwdata,             32'h0);
    check({tag, " pwstrb"},    {28'h0, pwstrb},    32'h0);
    check({tag, " rsp_rdata"}, rsp_rdata,          32'h0);
  endtask

  // Full transaction with rsp_ready high. lat = cycles from accept edge to
  // the first cycle with rsp_valid.
  task automatic issue(input string tag, input logic wr, input logic [15:0] addr,
                       input logic [31:0] wd, input logic [3:0] ws, input logic [2:0] pr,
                       input int lat, input logic [31:0] exp_rd, input logic exp_err);
    exp_t        e;
    int          n;
    logic [3:0]  ws_exp;
    ws_exp = wr ? ws : 4'b0000;
    $display("cmd %s: %s addr=0x%04h wdata=0x%08h wstrb=%b prot=%b",
             tag, wr ? "WR" : "RD", addr, wd, ws, pr);
    check({tag, " cmd_ready idle"}, {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_wstrb = ws;
    cmd_prot  = pr;
    e.rdata = exp_rd;
    e.err   = exp_err;
    exp_q.push_back(e);
    step();
    cmd_valid = 1'b0;
    n = 1;
    check({tag, " setup psel"},    {31'h0, psel},    32'h1);
    check({tag, " setup penable"}, {31'h0, penable}, 32'h0);
    check({tag, " setup pwrite"},  {31'h0, pwrite},  {31'h0, wr});
    check({tag, " setup paddr"},   {16'h0, paddr},   {16'h0, addr});
    check({tag, " setup pprot"},   {29'h0, pprot},   {29'h0, pr});
    check({tag, " setup pwdata"},  pwdata,           wd);
    check({tag, " setup pwstrb"},  {28'h0, pwstrb},  {28'h0, ws_exp});
    check({tag, " setup cmd_ready"}, {31'h0, cmd_ready}, 32'h0);
    step();
    n = 2;
    while (!rsp_valid && n < 300) begin
      check({tag, " access psel"},    {31'h0, psel},    32'h1);
      check({tag, " access penable"}, {31'h0, penable}, 32'h1);
      check({tag, " access paddr"},   {16'h0, paddr},   {16'h0, addr});
      check({tag, " access pwdata"},  pwdata,           wd);
      check({tag, " access pwstrb"},  {28'h0, pwstrb},  {28'h0, ws_exp});
      step();
      n++;
    end
    check({tag, " rsp latency"}, n, lat);
    check({tag, " resp psel"},    {31'h0, psel},    32'h0);
    check({tag, " resp penable"}, {31'h0, penable}, 32'h0);
    step();
    check({tag, " post cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
    check({tag, " post rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   n;
    int   bad;
    exp_t e;

    checks      = 0;
    errors      = 0;
    rsp_cnt     = 0;
    presetn     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = 16'h0;
    cmd_wdata   = 32'h0;
    cmd_wstrb   = 4'h0;
    cmd_prot    = 3'h0;
    rsp_ready   = 1'b1;
    wait_states = 1;
    err_mode    = 1'b0;

    fork
      monitor();
    join_none

    step();
    step();
    check_reset("reset");
    @(negedge pclk);
    presetn = 1'b1;
    step();

    // Register-bank style slave: pready in the second access cycle.
    wait_states = 1;
    issue("wr4", 1'b1, 16'h0004, 32'hA5A5_1234, 4'hF, 3'b000, 4, 32'h0, 1'b0);
    issue("rd4", 1'b0, 16'h0004, 32'h0,         4'hF, 3'b000, 4, 32'hA5A5_1234, 1'b0);

    // Zero-wait slave, partial strobes, nonzero prot.
    wait_states = 0;
    issue("wr8", 1'b1, 16'h0008, 32'h1122_3344, 4'b0101, 3'b101, 3, 32'h0, 1'b0);
    issue("rd8", 1'b0, 16'h0008, 32'hFFFF_0000, 4'hF,    3'b010, 3, 32'h0022_0044, 1'b0);

    // Error responses after 3 wait states (bus held for 4 access cycles).
    wait_states = 3;
    err_mode    = 1'b1;
    issue("rderr", 1'b0, 16'h0004, 32'h0, 4'h0, 3'b000, 6, 32'hA5A5_1234, 1'b1);
    wait_states = 0;
    issue("wrerr", 1'b1, 16'h0004, 32'h0, 4'hF, 3'b000, 3, 32'h0, 1'b1);
    err_mode    = 1'b0;
    issue("rd4b", 1'b0, 16'h0004, 32'h0, 4'h0, 3'b000, 3, 32'hA5A5_1234, 1'b0);

    // Response back-pressure: rsp_ready low 5 cycles, new command ignored.
    wait_states = 1;
    rsp_ready   = 1'b0;
    $display("cmd stall: RD addr=0x0008 with rsp_ready low");
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0008;
    e.rdata = 32'h0022_0044;
    e.err   = 1'b0;
    exp_q.push_back(e);
    step();
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    check("stall rsp latency", n, 4);
    for (int i = 0; i < 5; i++) begin
      check("stall rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("stall rsp_rdata", rsp_rdata, 32'h0022_0044);
      check("stall rsp_err",   {31'h0, rsp_err}, 32'h0);
      check("stall cmd_ready", {31'h0, cmd_ready}, 32'h0);
      check("stall psel",      {31'h0, psel}, 32'h0);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 16'h000C;
      cmd_wdata = 32'hFFFF_FFFF;
      cmd_wstrb = 4'hF;
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    check("stall rsp_valid held", {31'h0, rsp_valid}, 32'h1);
    step();
    check("stall release cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("stall release psel", {31'h0, psel}, 32'h0);
    issue("rdC", 1'b0, 16'h000C, 32'h0, 4'h0, 3'b000, 4, 32'h0, 1'b0);

    // Reset during the access phase of a write.
    wait_states = 2;
    $display("cmd midreset: WR addr=0x0010 wdata=0xdeadbeef, reset in access");
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0010;
    cmd_wdata = 32'hDEAD_BEEF;
    cmd_wstrb = 4'hF;
    cmd_prot  = 3'b011;
    step();
    cmd_valid = 1'b0;
    step();
    check("midreset in access", {31'h0, penable}, 32'h1);
    presetn = 1'b0;
    #1;
    check_reset("midreset");
    @(negedge pclk);
    presetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid || psel) bad++;
    end
    check("midreset quiet cycles", bad, 0);

    wait_states = 0;
    issue("wr0", 1'b1, 16'h0000, 32'h0BAD_F00D, 4'hF, 3'b000, 3, 32'h0, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
    // Never-ready slave: abort after 4 access cycles.
    wait_states = 1000;
    issue("tmo", 1'b0, 16'h0000, 32'h0, 4'h0, 3'b000, 6, 32'h0, 1'b1);
    // pready on the limit cycle completes normally.
    wait_states = 3;
    issue("tmoedge", 1'b0, 16'h0000, 32'h0, 4'h0, 3'b000, 6, 32'h0BAD_F00D, 1'b0);
`else
    // Never-ready slave: access phase persists.
    wait_states = 1000;
    $display("cmd hang: RD addr=0x0000 with pready tied low");
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0000;
    step();
    cmd_valid = 1'b0;
    step();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!(psel && penable) || rsp_valid) bad++;
      step();
    end
    check("hang access held 100 cycles", bad, 0);
    presetn = 1'b0;
    #1;
    check_reset("hangreset");
    @(negedge pclk);
    presetn = 1'b1;
    step();
`endif

    step();
    step();
    check("scoreboard drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
